// File: rtl/ps2_key_serializer.sv
// ps2_key_serializer: hps_io key events -> FIFO -> device-to-host PS/2 frames.
// Optional host inhibit sensing on ps2_clk_in when PS2_INHIBIT_EN is defined.
module ps2_key_serializer #(
  parameter int CLK_DIV    = 16,
  parameter int GAP_CYCLES = 64,
  parameter int FIFO_AW    = 3
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic [10:0]        ps2_key,
`ifdef PS2_INHIBIT_EN
  input  logic               ps2_clk_in,
`endif
  output logic               ps2_clk_out,
  output logic               ps2_data_out,
  output logic               busy,
  output logic               overflow,
  output logic [FIFO_AW:0]   fifo_level
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [DW-1:0] DMAX = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GMAX = GW'(GAP_CYCLES - 1);
  localparam logic [FIFO_AW-1:0] P1 = FIFO_AW'(1);
  localparam logic [FIFO_AW-1:0] P2 = FIFO_AW'(2);
  localparam logic [FIFO_AW:0] FULL = (FIFO_AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE, LOAD, SHIFT, GAP
  } state_t;

  state_t state;

  logic tog;
  logic armed;
  logic ev;

  logic [7:0] eb0, eb1, eb2;
  logic [1:0] n;
  logic [FIFO_AW:0] nw;
  logic [FIFO_AW:0] free;
  logic accept;

  logic [7:0] mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [7:0] head;
  logic pop;

  logic [10:0] frame;
  logic [3:0] bit_cnt;
  logic [DW-1:0] div_cnt;
  logic phase_lo;
  logic [GW-1:0] gap_cnt;
  logic line_ok;
  logic last_edge;
  logic abort;

`ifdef PS2_INHIBIT_EN
  assign line_ok = ps2_clk_in;
`else
  assign line_ok = 1'b1;
`endif

  assign ev = armed && (ps2_key[10] != tog);
  assign head = mem[rd_ptr];
  assign nw = (FIFO_AW+1)'(n);
  assign free = FULL - fifo_level;
  assign accept = ev && (free >= nw);
  assign busy = (state != IDLE) || (fifo_level != '0);

  assign last_edge = (state == SHIFT) && phase_lo &&
                     (div_cnt == DMAX) && (bit_cnt == 4'd10);
  assign abort = (state == SHIFT) && !phase_lo &&
                 (bit_cnt <= 4'd9) && !line_ok;

`ifdef PS2_INHIBIT_EN
  assign pop = last_edge;
`else
  assign pop = (state == LOAD);
`endif

  // Byte sequence for the current key event: [E0] [F0] code
  always_comb begin
    eb0 = ps2_key[7:0];
    eb1 = 8'h00;
    eb2 = 8'h00;
    n   = 2'd1;
    case ({ps2_key[8], ps2_key[9]})
      2'b00: begin
        eb0 = 8'hF0;
        eb1 = ps2_key[7:0];
        n   = 2'd2;
      end
      2'b01: begin
        eb0 = ps2_key[7:0];
        n   = 2'd1;
      end
      2'b10: begin
        eb0 = 8'hE0;
        eb1 = 8'hF0;
        eb2 = ps2_key[7:0];
        n   = 2'd3;
      end
      2'b11: begin
        eb0 = 8'hE0;
        eb1 = ps2_key[7:0];
        n   = 2'd2;
      end
    endcase
  end

  // Toggle capture; first cycle after reset only arms
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      tog   <= 1'b0;
      armed <= 1'b0;
    end else begin
      tog   <= ps2_key[10];
      armed <= 1'b1;
    end
  end

  // FIFO storage: all bytes of an event written in one cycle
  always_ff @(posedge clk_sys) begin
    if (accept) begin
      mem[wr_ptr] <= eb0;
      if (n >= 2'd2) mem[wr_ptr + P1] <= eb1;
      if (n == 2'd3) mem[wr_ptr + P2] <= eb2;
    end
  end

  // FIFO pointers, level and sticky overflow
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (pop) rd_ptr <= rd_ptr + P1;
      if (accept) wr_ptr <= wr_ptr + FIFO_AW'(n);
      fifo_level <= fifo_level
                    - (FIFO_AW+1)'(pop)
                    + (accept ? nw : '0);
      if (ev && !accept) overflow <= 1'b1;
    end
  end

  // Frame sequencer driving registered clock and data lines
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      ps2_clk_out  <= 1'b1;
      ps2_data_out <= 1'b1;
      frame        <= '1;
      bit_cnt      <= '0;
      div_cnt      <= '0;
      phase_lo     <= 1'b0;
      gap_cnt      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if ((fifo_level != '0) && line_ok) state <= LOAD;
        end
        LOAD: begin
          frame        <= {1'b1, ~^head, head, 1'b0};
          ps2_data_out <= 1'b0;
          ps2_clk_out  <= 1'b1;
          bit_cnt      <= '0;
          div_cnt      <= '0;
          phase_lo     <= 1'b0;
          state        <= SHIFT;
        end
        SHIFT: begin
          if (abort) begin
            ps2_clk_out  <= 1'b1;
            ps2_data_out <= 1'b1;
            gap_cnt      <= '0;
            state        <= GAP;
          end else if (div_cnt != DMAX) begin
            div_cnt <= div_cnt + DW'(1);
          end else begin
            div_cnt <= '0;
            if (!phase_lo) begin
              phase_lo    <= 1'b1;
              ps2_clk_out <= 1'b0;
            end else begin
              phase_lo    <= 1'b0;
              ps2_clk_out <= 1'b1;
              if (bit_cnt == 4'd10) begin
                ps2_data_out <= 1'b1;
                gap_cnt      <= '0;
                state        <= GAP;
              end else begin
                bit_cnt      <= bit_cnt + 4'd1;
                ps2_data_out <= frame[bit_cnt + 4'd1];
              end
            end
          end
        end
        GAP: begin
          if (!line_ok) gap_cnt <= '0;
          else if (gap_cnt == GMAX) state <= IDLE;
          else gap_cnt <= gap_cnt + GW'(1);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_serializer.sv
// tb_ps2_key_serializer: directed events, scoreboard of expected bytes,
// serial monitor decoding frames on falling ps2_clk_out.
module tb_ps2_key_serializer;

  localparam int CLK_DIV = 4;
  localparam int GAP     = 8;
  localparam int AW      = 3;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  logic [10:0] ps2_key = 11'h000;
`ifdef PS2_INHIBIT_EN
  logic ps2_clk_in = 1'b1;
`endif
  logic ps2_clk_out;
  logic ps2_data_out;
  logic busy;
  logic overflow;
  logic [AW:0] fifo_level;

  int n_checks = 0;
  int n_fail = 0;
  int frames_rx = 0;
  logic [7:0] exp_q[$];

  ps2_key_serializer #(
    .CLK_DIV(CLK_DIV),
    .GAP_CYCLES(GAP),
    .FIFO_AW(AW)
  ) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .ps2_key(ps2_key),
`ifdef PS2_INHIBIT_EN
    .ps2_clk_in(ps2_clk_in),
`endif
    .ps2_clk_out(ps2_clk_out),
    .ps2_data_out(ps2_data_out),
    .busy(busy),
    .overflow(overflow),
    .fifo_level(fifo_level)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_sys);
  endtask

  // Drive one key event; queue its bytes when it should be accepted
  task automatic send(input logic pr, input logic ext,
                      input logic [7:0] code, input bit acc);
    ps2_key = {~ps2_key[10], pr, ext, code};
    if (acc) begin
      if (ext) exp_q.push_back(8'hE0);
      if (!pr) exp_q.push_back(8'hF0);
      exp_q.push_back(code);
    end
    tick();
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (k < budget && (busy || exp_q.size() != 0)) begin
      tick();
      k++;
    end
    check("idle_timeout", int'(k < budget), 1);
  endtask

  task automatic check_frame(input logic [10:0] fr);
    logic [7:0] e;
    logic [7:0] d;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_frame: got %0h expected none", fr);
    end else begin
      e = exp_q.pop_front();
      d = fr[8:1];
      check("frame_start", int'(fr[0]), 0);
      check("frame_data", int'(d), int'(e));
      check("frame_parity", int'(fr[9]), int'(~^e));
      check("frame_stop", int'(fr[10]), 1);
    end
  endtask

  // Serial monitor: host-side sampling on falling clock
  initial begin
    logic prev_clk;
    int nbits;
    logic [10:0] fr;
    prev_clk = 1'b1;
    nbits = 0;
    fr = '0;
    forever begin
      @(negedge clk_sys);
      if (!reset_n) begin
        nbits = 0;
        prev_clk = 1'b1;
      end else begin
        if (prev_clk && !ps2_clk_out) begin
          fr[nbits] = ps2_data_out;
          nbits++;
          if (nbits == 11) begin
            nbits = 0;
            frames_rx++;
            check_frame(fr);
          end
        end
        prev_clk = ps2_clk_out;
      end
    end
  end

  initial begin
    int seen;
    int k;
    repeat (3) tick();
    check("rst_clk", int'(ps2_clk_out), 1);
    check("rst_data", int'(ps2_data_out), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_ovf", int'(overflow), 0);
    check("rst_level", int'(fifo_level), 0);
    reset_n = 1'b1;
    repeat (3) tick();
    check("armed_idle", int'(busy), 0);

    send(1'b1, 1'b0, 8'h1C, 1'b1);
    check("t1_level", int'(fifo_level), 1);
    tick();
    check("t1_data_pre", int'(ps2_data_out), 1);
    tick();
    check("t1_start", int'(ps2_data_out), 0);
    check("t1_clk_hi", int'(ps2_clk_out), 1);
    check("t1_popped", int'(fifo_level), 0);
    repeat (3) tick();
    check("t1_clk_hold", int'(ps2_clk_out), 1);
    tick();
    check("t1_clk_fall", int'(ps2_clk_out), 0);
    repeat (83) tick();
    check("t1_stop_lo", int'(ps2_clk_out), 0);
    tick();
    check("t1_stop_end", int'(ps2_clk_out), 1);
    check("t1_stop_data", int'(ps2_data_out), 1);
    repeat (7) tick();
    check("t1_gap_busy", int'(busy), 1);
    tick();
    check("t1_busy_fall", int'(busy), 0);
    wait_idle(50);

    send(1'b0, 1'b1, 8'h6B, 1'b1);
    wait_idle(1000);

    send(1'b1, 1'b1, 8'h75, 1'b1);
    check("t3_lvl2", int'(fifo_level), 2);
    send(1'b0, 1'b0, 8'h1C, 1'b1);
    check("t3_lvl4", int'(fifo_level), 4);
    send(1'b1, 1'b1, 8'h6B, 1'b1);
    check("t3_poppush", int'(fifo_level), 5);
    send(1'b0, 1'b1, 8'h74, 1'b1);
    check("t3_full", int'(fifo_level), 8);
    send(1'b0, 1'b1, 8'h72, 1'b0);
    check("t3_drop_lvl", int'(fifo_level), 8);
    check("t3_ovf", int'(overflow), 1);
    k = 0;
    while (k < 300 && fifo_level != 7) begin
      tick();
      k++;
    end
    check("t3_wait7", int'(k < 300), 1);
    send(1'b1, 1'b0, 8'h29, 1'b1);
    check("t3_accept", int'(fifo_level), 8);
    wait_idle(3000);
    check("t3_ovf_sticky", int'(overflow), 1);

    send(1'b1, 1'b0, 8'h1C, 1'b0);
    repeat (46) tick();
    check("t4_bit5_lo", int'(ps2_clk_out), 0);
    #2;
    reset_n = 1'b0;
    ps2_key = 11'h41C;
    #1;
    check("t4_clk", int'(ps2_clk_out), 1);
    check("t4_data", int'(ps2_data_out), 1);
    check("t4_level", int'(fifo_level), 0);
    check("t4_ovf", int'(overflow), 0);
    check("t4_busy", int'(busy), 0);
    repeat (2) tick();
    reset_n = 1'b1;
    seen = frames_rx;
    repeat (150) tick();
    check("t4_no_frame", frames_rx - seen, 0);
    check("t4_idle", int'(busy), 0);
    check("t4_lvl0", int'(fifo_level), 0);

    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
